// File: rtl/spi_frame_loader.sv
// spi_frame_loader
//   Reads one frame from an SPI EEPROM. On start it sends READ (0x03) and a
//   big-endian start address, then clocks in FRAME_BYTES data bytes and hands
//   each one to a downstream buffer. SCLK stops whenever the consumer stalls.
//   With CHECKSUM=1 one trailing byte is also read, and the frame is flagged
//   bad unless (sum of data bytes + trailer) mod 256 == 0.
//
// Ports
//   clk, nreset            system clock, synchronous active-low reset
//   start                  begins a frame when sampled high in IDLE
//   base_addr              EEPROM start address, captured at start
//   busy / done / err      frame in progress / end-of-frame pulse / checksum error (sticky)
//   eeprom_cs/clk/in/out   SPI mode 0: CS_n, SCLK, MOSI, MISO
//   byte_data/valid/ready  received byte stream
//   byte_index             index of byte_data within the frame
//   dbg_state              current FSM state
//
// Handshake: byte_valid rises with byte_data and byte_index stable and holds
// them until a cycle where byte_ready is also high; that cycle is the transfer,
// and byte_valid is low again on the following cycle. byte_valid never depends
// on byte_ready.
module spi_frame_loader #(
    parameter int FRAME_BYTES = 100,
    parameter int CNT_W       = 16,
    parameter int ADDR_BYTES  = 1,
    parameter int SCLK_DIV    = 1,
    parameter int CHECKSUM    = 0
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [8*ADDR_BYTES-1:0] base_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    eeprom_cs,
    output logic                    eeprom_clk,
    output logic                    eeprom_in,
    input  logic                    eeprom_out,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic [CNT_W-1:0]        byte_index,
    output logic [2:0]              dbg_state
);

    localparam int TX_W  = 8 + 8*ADDR_BYTES;
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_HOLD  = 3'd4,
        S_CHECK = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DIV_W-1:0]  r_div;
    logic              r_sclk;
    logic [4:0]        r_bit;
    logic [TX_W-1:0]   r_tx;
    logic [7:0]        r_rx;
    logic [7:0]        r_byte;
    logic [7:0]        r_sum;
    logic [CNT_W-1:0]  r_idx;
    logic              r_err;

    logic w_shifting;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_last_bit;
    logic w_last_byte;
    logic w_xfer;

    // SCLK toggles every SCLK_DIV cycles while a shifting state is active; a
    // bit ends on the falling toggle, which is also where MOSI advances.
    always_comb begin
        w_shifting  = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_DATA) || (r_state == S_CHECK);
        w_tick      = w_shifting && (r_div == DIV_W'(SCLK_DIV - 1));
        w_rise      = w_tick && !r_sclk;
        w_fall      = w_tick && r_sclk;
        w_last_bit  = (r_state == S_ADDR) ? (r_bit == 5'(8*ADDR_BYTES - 1))
                                          : (r_bit == 5'd7);
        w_last_byte = (r_idx == CNT_W'(FRAME_BYTES - 1));
        w_xfer      = (r_state == S_HOLD) && byte_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CMD;
            S_CMD:   if (w_fall && w_last_bit) w_next = S_ADDR;
            S_ADDR:  if (w_fall && w_last_bit) w_next = S_DATA;
            S_DATA:  if (w_fall && w_last_bit) w_next = S_HOLD;
            S_HOLD: begin
                if (w_xfer) begin
                    if (!w_last_byte)       w_next = S_DATA;
                    else if (CHECKSUM != 0) w_next = S_CHECK;
                    else                    w_next = S_FIN;
                end
            end
            S_CHECK: if (w_fall && w_last_bit) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        eeprom_cs  = (r_state == S_IDLE) || (r_state == S_FIN);
        busy       = !((r_state == S_IDLE) || (r_state == S_FIN));
        done       = (r_state == S_FIN);
        byte_valid = (r_state == S_HOLD);
        eeprom_in  = ((r_state == S_CMD) || (r_state == S_ADDR)) ? r_tx[TX_W-1] : 1'b0;
        eeprom_clk = r_sclk;
        byte_data  = r_byte;
        byte_index = r_idx;
        err        = r_err;
        dbg_state  = r_state;
    end

    // Datapath: SCLK divider, shift registers, byte counter and running sum
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            r_bit  <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_byte <= '0;
            r_sum  <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
        end else begin
            // Outside shifting states (including HOLD) SCLK parks low with the
            // divider cleared, so a resumed byte starts with a full low phase.
            if (w_shifting) begin
                if (w_tick) begin
                    r_div  <= '0;
                    r_sclk <= ~r_sclk;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_div  <= '0;
                r_sclk <= 1'b0;
            end

            if (w_rise) begin
                r_rx <= {r_rx[6:0], eeprom_out};
            end

            if (w_fall) begin
                r_bit <= w_last_bit ? 5'd0 : r_bit + 5'd1;
                r_tx  <= {r_tx[TX_W-2:0], 1'b0};
                if ((r_state == S_DATA) && w_last_bit) begin
                    r_byte <= r_rx;
                    r_sum  <= r_sum + r_rx;
                end
                if ((r_state == S_CHECK) && w_last_bit) begin
                    r_err <= ((r_sum + r_rx) != 8'd0);
                end
            end

            if ((r_state == S_IDLE) && start) begin
                r_tx  <= {8'h03, base_addr};
                r_bit <= '0;
                r_idx <= '0;
                r_sum <= '0;
                r_err <= 1'b0;
            end

            // The index stays on the last byte so it never exceeds FRAME_BYTES-1.
            if (w_xfer && !w_last_byte) begin
                r_idx <= r_idx + CNT_W'(1);
            end
        end
    end

endmodule
